// File: rtl/imsic_intp_file.sv
// One IMSIC interrupt file: eip/eie arrays, eidelivery/eithreshold, and a chunked
// priority sweep that publishes the lowest pending-and-enabled identity as topei.
module imsic_intp_file #(
  parameter  int NR_SRC     = 64,
  parameter  int NR_SRC_LEN = 32,
  parameter  int SCAN_WIDTH = 8,
  localparam int ID_W       = $clog2(NR_SRC)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NR_SRC_LEN-1:0] i_setipnum,
  input  logic                  i_setipnum_we,
  input  logic                  i_reg_we,
  input  logic [7:0]            i_reg_addr,
  input  logic [31:0]           i_reg_wdata,
  output logic [31:0]           o_reg_rdata,
  input  logic                  i_claim,
  output logic [ID_W-1:0]       o_topei,
  output logic                  o_irq,
  output logic                  o_busy
);

  localparam int NR_WORDS  = NR_SRC / 32;
  localparam int NR_CHUNKS = NR_SRC / SCAN_WIDTH;
  localparam int CNT_W     = (NR_CHUNKS > 1) ? $clog2(NR_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NR_CHUNKS - 1);
  localparam logic [7:0] ADDR_EIDELIVERY  = 8'h70;
  localparam logic [7:0] ADDR_EITHRESHOLD = 8'h72;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  logic [NR_SRC-1:0] eip_q, eip_d;
  logic [NR_SRC-1:0] eie_q, eie_d;
  logic              deliv_q, deliv_d;
  logic [ID_W-1:0]   thr_q, thr_d;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]   best_q;
  logic [ID_W-1:0]   topei_q, topei_d;
  logic              irq_q, irq_d;
  logic              busy_q;

  logic              eip_sel_s, eie_sel_s, word_ok_s;
  logic [5:0]        word_s;
  logic              eip_we_s, eie_we_s, thr_we_s, deliv_we_s;
  logic              setip_ok_s, claim_clr_s, change_s;
  logic [ID_W-1:0]   setip_id_s;
  logic [NR_SRC-1:0] qual_s;
  logic [ID_W-1:0]   cand_s, best_next_s;
  logic              last_s;

  // Indirect CSR address decode and event qualification
  always_comb begin
    eip_sel_s   = (i_reg_addr[7:6] == 2'b10);
    eie_sel_s   = (i_reg_addr[7:6] == 2'b11);
    word_s      = i_reg_addr[5:0];
    word_ok_s   = ({2'b00, word_s} < 8'(NR_WORDS));
    eip_we_s    = i_reg_we & eip_sel_s & word_ok_s;
    eie_we_s    = i_reg_we & eie_sel_s & word_ok_s;
    thr_we_s    = i_reg_we & (i_reg_addr == ADDR_EITHRESHOLD);
    deliv_we_s  = i_reg_we & (i_reg_addr == ADDR_EIDELIVERY);
    setip_ok_s  = i_setipnum_we & (i_setipnum != {NR_SRC_LEN{1'b0}})
                  & (i_setipnum < NR_SRC_LEN'(NR_SRC));
    setip_id_s  = i_setipnum[ID_W-1:0];
    claim_clr_s = i_claim & (topei_q != {ID_W{1'b0}});
    change_s    = setip_ok_s | eip_we_s | eie_we_s | thr_we_s | i_claim;
  end

  // Combinational register read; unmapped addresses read as zero
  always_comb begin
    o_reg_rdata = 32'h0000_0000;
    if (i_reg_addr == ADDR_EIDELIVERY) begin
      o_reg_rdata = {31'h0000_0000, deliv_q};
    end else if (i_reg_addr == ADDR_EITHRESHOLD) begin
      o_reg_rdata = 32'(thr_q);
    end else if ((eip_sel_s | eie_sel_s) & word_ok_s) begin
      for (int w = 0; w < NR_WORDS; w++) begin
        o_reg_rdata = (word_s == 6'(w)) ? (eip_sel_s ? eip_q[w*32 +: 32] : eie_q[w*32 +: 32])
                                        : o_reg_rdata;
      end
    end else begin
      o_reg_rdata = 32'h0000_0000;
    end
  end

  // Next-state of the register file: CSR write, then claim clear, then setipnum OR
  always_comb begin
    eip_d = eip_q;
    eie_d = eie_q;
    for (int w = 0; w < NR_WORDS; w++) begin
      eip_d[w*32 +: 32] = (eip_we_s && word_s == 6'(w)) ? i_reg_wdata : eip_d[w*32 +: 32];
      eie_d[w*32 +: 32] = (eie_we_s && word_s == 6'(w)) ? i_reg_wdata : eie_d[w*32 +: 32];
    end
    eip_d[topei_q]    = eip_d[topei_q] & ~claim_clr_s;
    eip_d[setip_id_s] = eip_d[setip_id_s] | setip_ok_s;
    eip_d[0]          = 1'b0;
    eie_d[0]          = 1'b0;
    thr_d   = thr_we_s   ? i_reg_wdata[ID_W-1:0] : thr_q;
    deliv_d = deliv_we_s ? i_reg_wdata[0]        : deliv_q;
  end

  // Qualification vector and lowest qualifying id in the chunk selected by cnt_q
  always_comb begin
    qual_s = {NR_SRC{1'b0}};
    for (int i = 0; i < NR_SRC; i++) begin
      qual_s[i] = eip_q[i] & eie_q[i]
                  & ((thr_q == {ID_W{1'b0}}) | (ID_W'(i) < thr_q));
    end
    cand_s = {ID_W{1'b0}};
    for (int c = 0; c < NR_CHUNKS; c++) begin
      for (int j = SCAN_WIDTH - 1; j >= 0; j--) begin
        cand_s = ((cnt_q == CNT_W'(c)) && qual_s[c*SCAN_WIDTH + j])
                 ? ID_W'(c*SCAN_WIDTH + j) : cand_s;
      end
    end
    best_next_s = (best_q != {ID_W{1'b0}}) ? best_q : cand_s;
    last_s      = (state_q == ST_SCAN) && !change_s && (cnt_q == LAST_CHUNK);
  end

  // Published topei and irq; a claim zeroes topei on the same edge to avoid a double claim
  always_comb begin
    if (i_claim) begin
      topei_d = {ID_W{1'b0}};
    end else if (last_s) begin
      topei_d = best_next_s;
    end else begin
      topei_d = topei_q;
    end
    irq_d = deliv_d & (topei_d != {ID_W{1'b0}});
  end

  // Register file state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      eip_q   <= {NR_SRC{1'b0}};
      eie_q   <= {NR_SRC{1'b0}};
      deliv_q <= 1'b0;
      thr_q   <= {ID_W{1'b0}};
    end else begin
      eip_q   <= eip_d;
      eie_q   <= eie_d;
      deliv_q <= deliv_d;
      thr_q   <= thr_d;
    end
  end

  // Sweep FSM; any change event restarts from chunk 0 without publishing
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      best_q  <= {ID_W{1'b0}};
      busy_q  <= 1'b0;
      topei_q <= {ID_W{1'b0}};
      irq_q   <= 1'b0;
    end else begin
      topei_q <= topei_d;
      irq_q   <= irq_d;
      case (state_q)
        ST_IDLE: begin
          if (change_s) begin
            state_q <= ST_SCAN;
            cnt_q   <= {CNT_W{1'b0}};
            best_q  <= {ID_W{1'b0}};
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (change_s) begin
            state_q <= ST_SCAN;
            cnt_q   <= {CNT_W{1'b0}};
            best_q  <= {ID_W{1'b0}};
            busy_q  <= 1'b1;
          end else if (cnt_q == LAST_CHUNK) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            best_q  <= {ID_W{1'b0}};
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_SCAN;
            cnt_q   <= cnt_q + CNT_W'(1'b1);
            best_q  <= best_next_s;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          best_q  <= {ID_W{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_topei = topei_q;
  assign o_irq   = irq_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_imsic_intp_file.sv
// Directed bench for imsic_intp_file (NR_SRC=64, SCAN_WIDTH=8, 8-cycle sweep).
module tb_imsic_intp_file;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_setipnum;
  logic        i_setipnum_we;
  logic        i_reg_we;
  logic [7:0]  i_reg_addr;
  logic [31:0] i_reg_wdata;
  logic [31:0] o_reg_rdata;
  logic        i_claim;
  logic [5:0]  o_topei;
  logic        o_irq;
  logic        o_busy;

  int checks_cnt;
  int errors_cnt;

  imsic_intp_file dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_setipnum    (i_setipnum),
    .i_setipnum_we (i_setipnum_we),
    .i_reg_we      (i_reg_we),
    .i_reg_addr    (i_reg_addr),
    .i_reg_wdata   (i_reg_wdata),
    .o_reg_rdata   (o_reg_rdata),
    .i_claim       (i_claim),
    .o_topei       (o_topei),
    .o_irq         (o_irq),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, applied at a negedge and released at the next
  task automatic drive(input bit we, input logic [7:0] a, input logic [31:0] d,
                       input bit sw, input logic [31:0] id, input bit cl);
    i_reg_we      = we;
    i_reg_addr    = a;
    i_reg_wdata   = d;
    i_setipnum_we = sw;
    i_setipnum    = id;
    i_claim       = cl;
    @(negedge i_clk);
    i_reg_we      = 1'b0;
    i_setipnum_we = 1'b0;
    i_claim       = 1'b0;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    drive(1'b1, a, d, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic setip(input logic [31:0] id);
    drive(1'b0, 8'h00, 32'd0, 1'b1, id, 1'b0);
  endtask

  task automatic claim();
    drive(1'b0, 8'h00, 32'd0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    i_reg_addr = a;
    #1;
    check_eq(tag, o_reg_rdata, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 32) begin
      @(negedge i_clk);
      n++;
    end
    check_eq(tag, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    checks_cnt    = 0;
    errors_cnt    = 0;
    i_rst         = 1'b1;
    i_setipnum    = 32'd0;
    i_setipnum_we = 1'b0;
    i_reg_we      = 1'b0;
    i_reg_addr    = 8'h00;
    i_reg_wdata   = 32'd0;
    i_claim       = 1'b0;
    repeat (2) @(negedge i_clk);
    check_eq("rst_topei", {26'd0, o_topei}, 32'd0);
    check_eq("rst_irq",   {31'd0, o_irq},   32'd0);
    check_eq("rst_busy",  {31'd0, o_busy},  32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // 1: enable, deliver, setipnum 5
    reg_wr(8'hC0, 32'hFFFF_FFFE);
    reg_wr(8'h70, 32'h0000_0003);
    setip(32'd5);
    for (int i = 0; i < 8; i++) begin
      check_eq("t1_busy", {31'd0, o_busy}, 32'd1);
      @(negedge i_clk);
    end
    check_eq("t1_busy_end", {31'd0, o_busy}, 32'd0);
    check_eq("t1_topei", {26'd0, o_topei}, 32'd5);
    check_eq("t1_irq", {31'd0, o_irq}, 32'd1);
    rd_chk("t1_eip0", 8'h80, 32'h0000_0020);
    rd_chk("t1_eie0", 8'hC0, 32'hFFFF_FFFE);
    rd_chk("t1_deliv", 8'h70, 32'h0000_0001);
    @(negedge i_clk);

    // 2: pending 9 and 40, setipnum 3 mid-sweep restarts without publishing 9
    reg_wr(8'h80, 32'h0000_0200);
    reg_wr(8'h81, 32'h0000_0100);
    reg_wr(8'hC1, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_busy_pre", {31'd0, o_busy}, 32'd1);
      check_eq("t2_stale_pre", {26'd0, o_topei}, 32'd5);
      @(negedge i_clk);
    end
    setip(32'd3);
    for (int i = 0; i < 8; i++) begin
      check_eq("t2_busy", {31'd0, o_busy}, 32'd1);
      check_eq("t2_no_publish", {26'd0, o_topei}, 32'd5);
      @(negedge i_clk);
    end
    check_eq("t2_busy_end", {31'd0, o_busy}, 32'd0);
    check_eq("t2_topei", {26'd0, o_topei}, 32'd3);
    check_eq("t2_irq", {31'd0, o_irq}, 32'd1);

    // 3: claim 3 to expose 9, then claim 9 and expect 40
    claim();
    check_eq("t3_claim3_topei", {26'd0, o_topei}, 32'd0);
    rd_chk("t3_eip0_a", 8'h80, 32'h0000_0200);
    wait_idle("t3_idle_a");
    check_eq("t3_topei9", {26'd0, o_topei}, 32'd9);
    claim();
    check_eq("t3_claim9_topei", {26'd0, o_topei}, 32'd0);
    check_eq("t3_claim9_irq", {31'd0, o_irq}, 32'd0);
    rd_chk("t3_eip0_b", 8'h80, 32'h0000_0000);
    @(negedge i_clk);
    for (int i = 0; i < 7; i++) begin
      check_eq("t3_busy", {31'd0, o_busy}, 32'd1);
      @(negedge i_clk);
    end
    check_eq("t3_busy_end", {31'd0, o_busy}, 32'd0);
    check_eq("t3_topei40", {26'd0, o_topei}, 32'd40);
    check_eq("t3_irq", {31'd0, o_irq}, 32'd1);

    // 4: threshold 10 masks 12 and 33; a write truncating to 0 disables it
    reg_wr(8'h72, 32'h0000_000A);
    reg_wr(8'h81, 32'h0000_0002);
    setip(32'd12);
    wait_idle("t4_idle_a");
    check_eq("t4_topei_thr", {26'd0, o_topei}, 32'd0);
    check_eq("t4_irq_thr", {31'd0, o_irq}, 32'd0);
    rd_chk("t4_thr", 8'h72, 32'h0000_000A);
    @(negedge i_clk);
    reg_wr(8'h72, 32'h0000_0040);
    rd_chk("t4_thr0", 8'h72, 32'h0000_0000);
    wait_idle("t4_idle_b");
    check_eq("t4_topei12", {26'd0, o_topei}, 32'd12);
    check_eq("t4_irq12", {31'd0, o_irq}, 32'd1);

    // 5: ignored inputs and simultaneous events
    @(negedge i_clk);
    setip(32'd0);
    check_eq("t5_busy_id0", {31'd0, o_busy}, 32'd0);
    rd_chk("t5_eip0", 8'h80, 32'h0000_1000);
    @(negedge i_clk);
    setip(32'd64);
    check_eq("t5_busy_id64", {31'd0, o_busy}, 32'd0);
    rd_chk("t5_eip1", 8'h81, 32'h0000_0002);
    @(negedge i_clk);
    reg_wr(8'h82, 32'hFFFF_FFFF);
    check_eq("t5_busy_k2", {31'd0, o_busy}, 32'd0);
    rd_chk("t5_rd_k2", 8'h82, 32'h0000_0000);
    rd_chk("t5_rd_71", 8'h71, 32'h0000_0000);
    @(negedge i_clk);
    drive(1'b0, 8'h00, 32'd0, 1'b1, 32'd12, 1'b1);
    check_eq("t5_sim_topei", {26'd0, o_topei}, 32'd0);
    check_eq("t5_sim_busy", {31'd0, o_busy}, 32'd1);
    rd_chk("t5_sim_eip0", 8'h80, 32'h0000_1000);
    wait_idle("t5_idle_a");
    check_eq("t5_topei12", {26'd0, o_topei}, 32'd12);
    drive(1'b1, 8'h80, 32'h0000_0001, 1'b1, 32'd7, 1'b0);
    rd_chk("t5_or_eip0", 8'h80, 32'h0000_0080);
    wait_idle("t5_idle_b");
    check_eq("t5_topei7", {26'd0, o_topei}, 32'd7);
    check_eq("t5_irq7", {31'd0, o_irq}, 32'd1);

    // 6: asynchronous reset in the middle of a sweep with 7, 33, 50 pending
    @(negedge i_clk);
    setip(32'd50);
    @(negedge i_clk);
    check_eq("t6_busy_pre", {31'd0, o_busy}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("t6_rst_topei", {26'd0, o_topei}, 32'd0);
    check_eq("t6_rst_irq", {31'd0, o_irq}, 32'd0);
    check_eq("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    rd_chk("t6_eip0", 8'h80, 32'h0000_0000);
    rd_chk("t6_eip1", 8'h81, 32'h0000_0000);
    rd_chk("t6_eie0", 8'hC0, 32'h0000_0000);
    rd_chk("t6_deliv", 8'h70, 32'h0000_0000);
    check_eq("t6_busy_post", {31'd0, o_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
